mac_transmit: RTL and testbench
===============================

Name: mac_transmit

Overview:
- Downstream consumer of the operand-collection stage.
- Takes a complete operation (a, b, wide c) on a single-cycle operation-valid pulse and computes result = a*b + c over a 2-stage pipeline.
- Buffers results in a small FIFO and serializes each 2*DW result into two data_t words (low, then high) on a valid/ready write stream toward the memory write path.
- The upstream stage has no backpressure, so this block detects and flags dropped operations.

Parameters:
- DW, 32, width of data_t; w_data_t is 2*DW. Both are taken from config_pkg and are not overridden locally.
- FIFO_DEPTH, 2, number of result entries buffered (power of two, >= 2).

Ports:
- clk  input  1  clock
- arst_ni  input  1  asynchronous active-low reset
- operand_a_i  input  DW  multiplicand (data_t)
- operand_b_i  input  DW  multiplier (data_t)
- operand_c_i  input  2*DW  addend (w_data_t)
- operation_valid_i  input  1  one-cycle pulse; operands are valid only in this cycle
- wr_data_o  output  DW  serialized result word
- wr_data_valid_o  output  1  wr_data_o valid
- wr_data_ready_i  input  1  downstream accepts word
- busy_o  output  1  any operation in pipeline, FIFO or serializer
- overflow_o  output  1  sticky: at least one operation was dropped

Behaviour:
- Reset: clk is the only clock; arst_ni is asynchronous and active-low. On reset, all pipeline valids, FIFO pointers and the serializer state clear; wr_data_valid_o=0, wr_data_o=0, busy_o=0, overflow_o=0. Datapath registers need no reset.
- Reset mid-operation: in-flight and buffered results are discarded silently. Streaming restarts clean, always with a low word.
- Arithmetic:
  - All operands are unsigned.
  - S1 registers prod = a*b (2*DW bits, exact) and registers c.
  - S2 computes sum = prod + c, truncated to 2*DW bits; the carry-out is discarded.
  - S2 pushes sum into the FIFO in the same cycle.
- Latency: operation_valid_i in cycle N gives a FIFO push at the end of N+1. wr_data_valid_o rises in cycle N+2 with the low word if the FIFO was empty and the serializer idle.
- Admission:
  - occ = FIFO count + S1 valid, evaluated before any pop in the current cycle (conservative).
  - operation_valid_i with occ < FIFO_DEPTH: accepted.
  - Otherwise: the operation is dropped, overflow_o is set, and it stays set until reset.
  - A push and a pop in the same cycle are legal; the count is unchanged.
- Serializer FSM states:
  - IDLE: FIFO non-empty -> SEND_LO.
  - SEND_LO: wr_data_o = head[DW-1:0], valid=1. On handshake -> SEND_HI.
  - SEND_HI: wr_data_o = head[2DW-1:DW], valid=1. On handshake the head is popped; go to SEND_LO if another entry remains (FIFO count > 1 before the pop), else IDLE.
- Handshake rules:
  - A transfer occurs when valid & ready.
  - Once asserted, wr_data_valid_o and wr_data_o stay stable until the transfer.
  - wr_data_valid_o never depends combinationally on wr_data_ready_i.
  - Back-to-back results stream with no idle cycles at full ready.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- busy_o = S1 valid | FIFO non-empty | state != IDLE.

Decomposition:
- config_pkg already holds data_t and w_data_t. Add to it:
  - the serializer state enum (IDLE, SEND_LO, SEND_HI);
  - localparam MAC_FIFO_DEPTH = 2.
- One sub-module: result_fifo, a synchronous FIFO of w_data_t with push/pop/count/empty/full. It must not overflow internally, since admission guarantees space.

Test Plan:
- Basic (DW=32, ready=1): a=3, b=5, c=7 -> words 0x00000016 then 0x00000000 in cycles N+2 and N+3; busy_o falls after the second transfer.
- Max operands: a=b=0xFFFFFFFF, c=1 -> 0x00000002 then 0xFFFFFFFE.
- Wrap: a=b=0xFFFFFFFF, c=0x00000001_FFFFFFFF -> 0x00000000, 0x00000000 (carry discarded); overflow_o stays 0.
- Backpressure/overflow: ready=0; three operations in consecutive cycles (1*1+0, 2*1+0, 3*1+0).
  - Third is dropped; overflow_o=1.
  - Then ready=1 -> stream 1, 0, 2, 0.
  - wr_data_o stays stable while stalled.
- Random ready toggling over 100 ops spaced 4 cycles apart -> every result matches the a*b+c model in order, low word first; no drops.
- Reset asserted during SEND_HI of the first of two buffered results -> wr_data_valid_o=0 immediately; after release, a new op (a=2, b=2, c=0) yields 0x00000004, 0x00000000 only.

Source files
------------

// File: rtl/config_pkg.sv
// Shared datapath widths plus the MAC transmit serializer types.
package config_pkg;

  localparam int DW = 32;

  typedef logic [DW-1:0]   data_t;
  typedef logic [2*DW-1:0] w_data_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_LO,
    SEND_HI
  } ser_state_e;

  localparam int MAC_FIFO_DEPTH = 2;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of wide MAC results; pointers carry an extra wrap bit.
module result_fifo
  import config_pkg::*;
#(
  parameter int DEPTH = MAC_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       arst_ni,
  input  logic                       push,
  input  w_data_t                    push_data,
  input  logic                       pop,
  output w_data_t                    head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  w_data_t     mem [DEPTH];

  // Writes and reads are gated so a stray push or pop can never corrupt the pointers.
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mac_transmit.sv
// Two-stage a*b+c MAC feeding a result FIFO, serialized as low/high words on a valid/ready stream.
module mac_transmit
  import config_pkg::*;
#(
  parameter int FIFO_DEPTH = MAC_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    arst_ni,
  input  data_t   operand_a_i,
  input  data_t   operand_b_i,
  input  w_data_t operand_c_i,
  input  logic    operation_valid_i,
  output data_t   wr_data_o,
  output logic    wr_data_valid_o,
  input  logic    wr_data_ready_i,
  output logic    busy_o,
  output logic    overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic w_data_t mac_sum(w_data_t prod, w_data_t addend);
    return prod + addend;
  endfunction

  logic            vld_p1;
  w_data_t         prod_p1;
  w_data_t         c_p1;
  w_data_t         sum_p2;
  logic            accept;
  logic [AW+1:0]   occ;
  w_data_t         fifo_head;
  logic [AW:0]     fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  ser_state_e      state_q;
  ser_state_e      state_d;

  // Occupancy counts the result still in S1 so a push can never find the FIFO full.
  assign occ    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, vld_p1};
  assign accept = operation_valid_i & ~fifo_full & (occ < (AW+2)'(FIFO_DEPTH));

  // S1: register exact product and addend
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_p1     <= 1'b0;
      overflow_o <= 1'b0;
      state_q    <= IDLE;
    end else begin
      vld_p1  <= accept;
      state_q <= state_d;
      if (operation_valid_i && !accept) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p1 <= w_data_t'(operand_a_i) * w_data_t'(operand_b_i);
      c_p1    <= operand_c_i;
    end
  end

  // S2: sum (carry-out dropped) pushed straight into the FIFO
  assign sum_p2 = mac_sum(prod_p1, c_p1);

  result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .arst_ni  (arst_ni),
    .push     (vld_p1),
    .push_data(sum_p2),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Leaving IDLE on the push itself lets the low word appear the cycle the entry lands.
  always_comb begin
    state_d         = state_q;
    wr_data_valid_o = 1'b0;
    wr_data_o       = '0;
    pop             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || vld_p1) state_d = SEND_LO;
      end
      SEND_LO: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = fifo_head[DW-1:0];
        if (wr_data_ready_i) state_d = SEND_HI;
      end
      SEND_HI: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = fifo_head[2*DW-1:DW];
        if (wr_data_ready_i) begin
          pop     = 1'b1;
          state_d = (fifo_count > (AW+1)'(1) || vld_p1) ? SEND_LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = vld_p1 | ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_mac_transmit.sv
// Directed and ready-toggling bench for mac_transmit with a queue-based result model.
module tb_mac_transmit;
  import config_pkg::*;

  logic    clk = 1'b0;
  logic    arst_ni;
  data_t   a, b;
  w_data_t c;
  logic    op_valid;
  data_t   wr_data;
  logic    wr_valid;
  logic    wr_ready;
  logic    busy;
  logic    ovf;

  int vectors = 0;
  int fails   = 0;

  mac_transmit dut (
    .clk              (clk),
    .arst_ni          (arst_ni),
    .operand_a_i      (a),
    .operand_b_i      (b),
    .operand_c_i      (c),
    .operation_valid_i(op_valid),
    .wr_data_o        (wr_data),
    .wr_data_valid_o  (wr_valid),
    .wr_data_ready_i  (wr_ready),
    .busy_o           (busy),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted op contributes low then high word of (a*b+c) mod 2^64.
  // An op is admitted if fewer than MAC_FIFO_DEPTH earlier accepted results are
  // still outstanding (not yet fully popped by a high-word transfer).
  data_t exp_q[$];
  int    outstanding = 0;
  bit    half        = 0;
  bit    exp_ovf     = 0;
  bit    stalled     = 0;
  data_t stall_data;

  always @(negedge clk) begin
    bit hi_pop;
    w_data_t r;
    if (!arst_ni) begin
      exp_q.delete();
      outstanding = 0;
      half        = 0;
      exp_ovf     = 0;
      stalled     = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(wr_valid), 64'd1);
        check("stall_data", 64'(wr_data), 64'(stall_data));
      end
      check("overflow_model", 64'(ovf), 64'(exp_ovf));
      hi_pop = 0;
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(wr_data), 64'hDEAD_0000_DEAD_0000);
        end else begin
          check("stream_word", 64'(wr_data), 64'(exp_q.pop_front()));
        end
        if (half) hi_pop = 1;
        half = ~half;
      end
      if (op_valid) begin
        if (outstanding < MAC_FIFO_DEPTH) begin
          r = 64'(a) * 64'(b) + c;
          exp_q.push_back(r[31:0]);
          exp_q.push_back(r[63:32]);
          outstanding++;
        end else begin
          exp_ovf = 1;
        end
      end
      if (hi_pop) outstanding--;
      stalled    = wr_valid && !wr_ready;
      stall_data = wr_data;
    end
  end

  task automatic drive(input logic v, input data_t ta, input data_t tb, input w_data_t tc);
    @(posedge clk); #1;
    op_valid = v; a = ta; b = tb; c = tc;
  endtask

  task automatic wait_xfer(input string name, input data_t exp);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        got = 1;
        check(name, 64'(wr_data), 64'(exp));
      end
    end
    if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  initial begin
    arst_ni = 1'b0; op_valid = 1'b0; a = '0; b = '0; c = '0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(wr_valid), 64'd0);
    check("rst_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1; arst_ni = 1'b1; wr_ready = 1'b1;

    // Basic: 3*5+7 = 22, exact latency
    drive(1, 32'd3, 32'd5, 64'd7);
    @(negedge clk); check("basic_n_valid", 64'(wr_valid), 64'd0);
    drive(0, '0, '0, '0);
    @(negedge clk); check("basic_n1_valid", 64'(wr_valid), 64'd0);
    check("basic_n1_busy", 64'(busy), 64'd1);
    @(negedge clk); check("basic_n2_valid", 64'(wr_valid), 64'd1);
    check("basic_lo", 64'(wr_data), 64'h16);
    @(negedge clk); check("basic_n3_valid", 64'(wr_valid), 64'd1);
    check("basic_hi", 64'(wr_data), 64'h0);
    check("basic_n3_busy", 64'(busy), 64'd1);
    @(negedge clk); check("basic_n4_valid", 64'(wr_valid), 64'd0);
    check("basic_n4_busy", 64'(busy), 64'd0);

    // Max operands: (2^32-1)^2 + 1 = 0xFFFFFFFE_00000002
    drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    drive(0, '0, '0, '0);
    wait_xfer("max_lo", 32'h0000_0002);
    wait_xfer("max_hi", 32'hFFFF_FFFE);

    // Wrap: 0xFFFFFFFE_00000001 + 0x1_FFFFFFFF = 2^64 -> 0
    drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_FFFF_FFFF);
    drive(0, '0, '0, '0);
    wait_xfer("wrap_lo", 32'h0);
    wait_xfer("wrap_hi", 32'h0);
    @(negedge clk); check("wrap_ovf", 64'(ovf), 64'd0);

    // Backpressure and overflow: third op dropped
    @(posedge clk); #1; wr_ready = 1'b0;
    drive(1, 32'd1, 32'd1, 64'd0);
    drive(1, 32'd2, 32'd1, 64'd0);
    drive(1, 32'd3, 32'd1, 64'd0);
    drive(0, '0, '0, '0);
    repeat (4) @(negedge clk);
    check("ovf_set", 64'(ovf), 64'd1);
    check("stalled_valid", 64'(wr_valid), 64'd1);
    check("stalled_lo", 64'(wr_data), 64'd1);
    @(posedge clk); #1; wr_ready = 1'b1;
    wait_xfer("bp_w0", 32'd1);
    wait_xfer("bp_w1", 32'd0);
    wait_xfer("bp_w2", 32'd2);
    wait_xfer("bp_w3", 32'd0);
    drain("bp_drain");
    check("ovf_sticky", 64'(ovf), 64'd1);

    // Clear overflow before the ready-toggling run
    @(posedge clk); #1; arst_ni = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; arst_ni = 1'b1;

    // Random ready, 100 ops four cycles apart; ready forced high every other cycle
    for (int k = 0; k < 100; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        op_valid = (j == 0);
        a = $urandom(); b = $urandom(); c = {$urandom(), $urandom()};
        wr_ready = (j % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1; op_valid = 1'b0; wr_ready = 1'b1;
    drain("rand_drain");
    check("rand_no_drop", 64'(ovf), 64'd0);

    // Reset during SEND_HI of the first of two buffered results
    @(posedge clk); #1; wr_ready = 1'b0;
    drive(1, 32'd10, 32'd1, 64'd0);
    drive(1, 32'd20, 32'd1, 64'd0);
    drive(0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rsthi_lo_ready", 64'(wr_data), 64'd10);
    @(posedge clk); #1; wr_ready = 1'b1;
    @(posedge clk); #1; wr_ready = 1'b0;
    @(negedge clk); check("rsthi_in_hi", 64'(wr_valid), 64'd1);
    @(posedge clk); #1; arst_ni = 1'b0;
    #1;
    check("rsthi_valid_now", 64'(wr_valid), 64'd0);
    check("rsthi_busy_now", 64'(busy), 64'd0);
    @(negedge clk);
    @(posedge clk); #1; arst_ni = 1'b1; wr_ready = 1'b1;
    drive(1, 32'd2, 32'd2, 64'd0);
    drive(0, '0, '0, '0);
    wait_xfer("after_rst_lo", 32'd4);
    wait_xfer("after_rst_hi", 32'd0);
    repeat (5) @(negedge clk);
    check("after_rst_quiet", 64'(wr_valid), 64'd0);
    check("after_rst_model_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
